// File: rtl/mem_write_buffer_if.sv
// Signal bundle between the L1 cache, the write-back buffer and external memory.
// The buffer takes the slave view; the cache/memory environment takes the master view.
interface mem_write_buffer_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] cache_addr_i;
    logic [DATA_WIDTH-1:0] cache_data_i;
    logic                  cache_cs_i;
    logic                  cache_we_i;
    logic [DATA_WIDTH-1:0] cache_data_o;
    logic                  cache_ack_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic                  mem_cs_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_data_i;
    logic                  mem_ack_i;
    logic                  empty_o;

    modport slave (
        input  cache_addr_i, cache_data_i, cache_cs_i, cache_we_i, mem_data_i, mem_ack_i,
        output cache_data_o, cache_ack_o, mem_addr_o, mem_data_o, mem_cs_o, mem_we_o, empty_o
    );

    modport master (
        output cache_addr_i, cache_data_i, cache_cs_i, cache_we_i, mem_data_i, mem_ack_i,
        input  cache_data_o, cache_ack_o, mem_addr_o, mem_data_o, mem_cs_o, mem_we_o, empty_o
    );
endinterface

// File: rtl/mem_write_buffer.sv
// Write-back buffer between an L1 cache and external memory: queues evicted lines,
// merges repeat writes, serves reads from buffered lines, and lets read misses jump the drain queue.
module mem_write_buffer #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_write_buffer_if.slave bus
);
    localparam int LINE_W = ADDR_WIDTH - 5;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, READ} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [LINE_W-1:0]     rd_line_q, rd_line_d;
    logic                  cache_ack_q, cache_ack_d;
    logic [DATA_WIDTH-1:0] cache_data_q, cache_data_d;
    logic                  mem_cs_q, mem_cs_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [LINE_W-1:0]     line_q [DEPTH];
    logic [LINE_W-1:0]     line_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];

    logic                  req, push, pop, rd_miss, wr_hit, rd_hit;
    logic [LINE_W-1:0]     req_line;
    logic [PTR_W-1:0]      idx, wr_idx, tail;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_addr_bits;

    function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d      = state_q;
        head_d       = head_q;
        count_d      = count_q;
        rd_pend_d    = rd_pend_q;
        rd_line_d    = rd_line_q;
        cache_ack_d  = 1'b0;
        cache_data_d = cache_data_q;
        mem_cs_d     = mem_cs_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        line_d       = line_q;
        data_d       = data_q;
        push         = 1'b0;
        pop          = 1'b0;
        rd_miss      = 1'b0;
        wr_hit       = 1'b0;
        rd_hit       = 1'b0;
        idx          = '0;
        wr_idx       = '0;
        rd_data      = '0;
        req_line     = bus.cache_addr_i[ADDR_WIDTH-1:5];
        tail         = slot(head_q, int'(count_q));

        // The ack cycle and a read already waiting on memory both block a fresh acceptance.
        req = bus.cache_cs_i && !cache_ack_q && !rd_pend_q && (state_q != READ);

        // Walk oldest to youngest so the last match is the youngest copy of the line.
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(count_q)) begin
                idx = slot(head_q, k);
                if (line_q[idx] == req_line) begin
                    rd_hit  = 1'b1;
                    rd_data = data_q[idx];
                    if (!(k == 0 && state_q == DRAIN)) begin
                        wr_hit = 1'b1;
                        wr_idx = idx;
                    end
                end
            end
        end

        if (req && bus.cache_we_i) begin
            if (wr_hit) begin
                data_d[wr_idx] = bus.cache_data_i;
                cache_ack_d    = 1'b1;
            end else if (count_q < CNT_W'(DEPTH)) begin
                push         = 1'b1;
                line_d[tail] = req_line;
                data_d[tail] = bus.cache_data_i;
                cache_ack_d  = 1'b1;
            end
        end else if (req) begin
            if (rd_hit) begin
                cache_data_d = rd_data;
                cache_ack_d  = 1'b1;
            end else begin
                rd_miss = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (rd_pend_q || rd_miss) begin
                    state_d    = READ;
                    mem_cs_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {(rd_pend_q ? rd_line_q : req_line), 5'b0};
                    rd_pend_d  = 1'b0;
                end else if (count_q != '0) begin
                    // Taken from the _d copy so a same-edge overwrite of the head still reaches memory.
                    state_d    = DRAIN;
                    mem_cs_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = {line_d[head_q], 5'b0};
                    mem_data_d = data_d[head_q];
                end
            end
            DRAIN: begin
                if (bus.mem_ack_i) begin
                    pop      = 1'b1;
                    state_d  = IDLE;
                    mem_cs_d = 1'b0;
                    mem_we_d = 1'b0;
                end
            end
            READ: begin
                if (bus.mem_ack_i) begin
                    cache_data_d = bus.mem_data_i;
                    cache_ack_d  = 1'b1;
                    state_d      = IDLE;
                    mem_cs_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_miss && state_q != IDLE) begin
            rd_pend_d = 1'b1;
            rd_line_d = req_line;
        end

        if (pop) head_d = slot(head_q, 1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the pre-edge values together.
        if (rst) begin
            state_q      <= IDLE;
            head_q       <= '0;
            count_q      <= '0;
            rd_pend_q    <= 1'b0;
            rd_line_q    <= '0;
            cache_ack_q  <= 1'b0;
            cache_data_q <= '0;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            count_q      <= count_d;
            rd_pend_q    <= rd_pend_d;
            rd_line_q    <= rd_line_d;
            cache_ack_q  <= cache_ack_d;
            cache_data_q <= cache_data_d;
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // NOTE: line storage is not reset; count_q = 0 already marks every slot as invalid.
    always_ff @(posedge clk) begin
        line_q <= line_d;
        data_q <= data_d;
    end

    assign bus.cache_ack_o  = cache_ack_q;
    assign bus.cache_data_o = cache_data_q;
    assign bus.mem_cs_o     = mem_cs_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign bus.empty_o      = (count_q == '0) && (state_q == IDLE);

    assign unused_addr_bits = ^bus.cache_addr_i[4:0];
endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: the bench plays both the L1 cache and external memory.
module tb_mem_write_buffer;
    localparam int DW    = 256;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_write_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.cache_cs_i   = 1'b0;
        bus.cache_we_i   = 1'b0;
        bus.cache_addr_i = '0;
        bus.cache_data_i = '0;
        bus.mem_ack_i    = 1'b0;
        bus.mem_data_i   = '0;
    endtask

    // Holds a cache write until it is acked or the bound expires; returns in the ack cycle.
    task automatic cache_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input int bound, output bit acked);
        acked            = 1'b0;
        bus.cache_cs_i   = 1'b1;
        bus.cache_we_i   = 1'b1;
        bus.cache_addr_i = addr;
        bus.cache_data_i = data;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (bus.cache_ack_o) begin
                acked = 1'b1;
                break;
            end
        end
        bus.cache_cs_i = 1'b0;
        bus.cache_we_i = 1'b0;
    endtask

    // Memory side: waits for a request, captures it, acks after 'delay' cycles.
    task automatic mem_serve(input int delay, output bit seen, output logic [AW-1:0] addr,
                             output logic [DW-1:0] data, output logic we);
        seen = 1'b0;
        addr = '0;
        data = '0;
        we   = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.mem_cs_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (seen) begin
            addr = bus.mem_addr_o;
            data = bus.mem_data_o;
            we   = bus.mem_we_o;
            repeat (delay) tick();
            bus.mem_ack_i = 1'b1;
            tick();
            bus.mem_ack_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        checks++;
        if ({bus.cache_ack_o, bus.mem_cs_o, bus.mem_we_o, bus.empty_o} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_during_flags: ack/cs/we/empty got %b expected 0001",
                     {bus.cache_ack_o, bus.mem_cs_o, bus.mem_we_o, bus.empty_o});
        end
        checks++;
        if (bus.mem_addr_o !== '0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 0", bus.mem_addr_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.cache_ack_o, bus.mem_cs_o, bus.mem_we_o, bus.empty_o} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_after_flags: ack/cs/we/empty got %b expected 0001",
                     {bus.cache_ack_o, bus.mem_cs_o, bus.mem_we_o, bus.empty_o});
        end
        checks++;
        if ({bus.cache_data_o, bus.mem_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: cache_data %h mem_data %h expected 0",
                     bus.cache_data_o, bus.mem_data_o);
        end
    endtask

    task automatic test_single_write();
        logic [DW-1:0] pat = {32{8'hAA}};
        bus.cache_cs_i   = 1'b1;
        bus.cache_we_i   = 1'b1;
        bus.cache_addr_i = 32'h400;
        bus.cache_data_i = pat;
        tick();
        checks++;
        if (bus.cache_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL single_ack: got %b expected 1", bus.cache_ack_o);
        end
        bus.cache_cs_i = 1'b0;
        bus.cache_we_i = 1'b0;
        tick();
        checks++;
        if ({bus.cache_ack_o, bus.mem_cs_o, bus.mem_we_o, bus.mem_addr_o} !== {3'b011, 32'h400}) begin
            errors++;
            $display("FAIL single_issue: ack/cs/we %b addr %h expected 011 addr 400",
                     {bus.cache_ack_o, bus.mem_cs_o, bus.mem_we_o}, bus.mem_addr_o);
        end
        checks++;
        if (bus.mem_data_o !== pat) begin
            errors++;
            $display("FAIL single_data: got %h expected %h", bus.mem_data_o, pat);
        end
        repeat (9) tick();
        checks++;
        if ({bus.mem_cs_o, bus.mem_addr_o, bus.mem_data_o} !== {1'b1, 32'h400, pat}) begin
            errors++;
            $display("FAIL single_hold: cs %b addr %h expected cs 1 addr 400 stable",
                     bus.mem_cs_o, bus.mem_addr_o);
        end
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        checks++;
        if ({bus.cache_ack_o, bus.mem_cs_o, bus.empty_o} !== 3'b001) begin
            errors++;
            $display("FAIL single_done: ack/cs/empty got %b expected 001",
                     {bus.cache_ack_o, bus.mem_cs_o, bus.empty_o});
        end
    endtask

    task automatic test_overflow();
        bit            ok, seen, early;
        int            acks = 0;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        for (int i = 0; i < 4; i++) begin
            cache_write(32'(i * 32), DW'(i + 1), 4, ok);
            if (ok) acks++;
        end
        checks++;
        if (acks !== 4) begin
            errors++;
            $display("FAIL full_first_four: acks got %0d expected 4", acks);
        end
        bus.cache_cs_i   = 1'b1;
        bus.cache_we_i   = 1'b1;
        bus.cache_addr_i = 32'h80;
        bus.cache_data_i = DW'(5);
        early = 1'b0;
        repeat (6) begin
            tick();
            if (bus.cache_ack_o) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL full_stall: fifth write acked while full, got %b expected 0", early);
        end
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        checks++;
        if (bus.cache_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_edge: ack got %b expected 0", bus.cache_ack_o);
        end
        tick();
        checks++;
        if (bus.cache_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL full_accept: ack got %b expected 1", bus.cache_ack_o);
        end
        bus.cache_cs_i = 1'b0;
        bus.cache_we_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            mem_serve(1, seen, a, d, w);
            checks++;
            if ({seen, w, a, d} !== {1'b1, 1'b1, 32'(i * 32), DW'(i + 1)}) begin
                errors++;
                $display("FAIL full_drain%0d: seen %b we %b addr %h data %h expected 1 1 %h %h",
                         i, seen, w, a, d, 32'(i * 32), DW'(i + 1));
            end
        end
        checks++;
        if (bus.empty_o !== 1'b1) begin
            errors++;
            $display("FAIL full_empty: got %b expected 1", bus.empty_o);
        end
    endtask

    task automatic test_read_hit();
        bit            seen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        bus.cache_cs_i   = 1'b1;
        bus.cache_we_i   = 1'b1;
        bus.cache_addr_i = 32'h20;
        bus.cache_data_i = DW'(8'h11);
        tick();
        checks++;
        if (bus.cache_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL hit_wr_ack: got %b expected 1", bus.cache_ack_o);
        end
        bus.cache_we_i   = 1'b0;
        bus.cache_data_i = '0;
        tick();
        checks++;
        if (bus.cache_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL hit_no_double: ack got %b expected 0", bus.cache_ack_o);
        end
        tick();
        checks++;
        if ({bus.cache_ack_o, bus.cache_data_o} !== {1'b1, DW'(8'h11)}) begin
            errors++;
            $display("FAIL hit_rd_data: ack %b data %h expected 1 %h",
                     bus.cache_ack_o, bus.cache_data_o, DW'(8'h11));
        end
        checks++;
        if ({bus.mem_cs_o, bus.mem_we_o, bus.mem_addr_o} !== {2'b11, 32'h20}) begin
            errors++;
            $display("FAIL hit_no_mem_read: cs/we %b addr %h expected 11 addr 20",
                     {bus.mem_cs_o, bus.mem_we_o}, bus.mem_addr_o);
        end
        bus.cache_cs_i = 1'b0;
        mem_serve(1, seen, a, d, w);
        checks++;
        if ({seen, w, a, d} !== {1'b1, 1'b1, 32'h20, DW'(8'h11)} || bus.empty_o !== 1'b1) begin
            errors++;
            $display("FAIL hit_drain: seen %b we %b addr %h data %h empty %b expected 1 1 20 11 empty 1",
                     seen, w, a, d, bus.empty_o);
        end
    endtask

    task automatic test_merge();
        bit            ok, seen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        logic [DW-1:0] exp_d [3];
        logic [AW-1:0] exp_a [3];
        exp_a[0] = 32'h000; exp_d[0] = {8{32'hAAAA5555}};
        exp_a[1] = 32'h040; exp_d[1] = DW'(2);
        exp_a[2] = 32'h000; exp_d[2] = {8{32'h5555AAAA}};
        cache_write(32'h000, exp_d[0], 4, ok);
        cache_write(32'h040, DW'(1), 4, ok);
        cache_write(32'h040, DW'(2), 4, ok);
        cache_write(32'h000, exp_d[2], 4, ok);
        checks++;
        if ({ok, bus.mem_cs_o, bus.mem_addr_o} !== {2'b11, 32'h000}) begin
            errors++;
            $display("FAIL merge_in_flight: ok %b cs %b addr %h expected 1 1 000",
                     ok, bus.mem_cs_o, bus.mem_addr_o);
        end
        for (int i = 0; i < 3; i++) begin
            mem_serve(1, seen, a, d, w);
            checks++;
            if ({seen, w, a, d} !== {1'b1, 1'b1, exp_a[i], exp_d[i]}) begin
                errors++;
                $display("FAIL merge_drain%0d: seen %b we %b addr %h data %h expected 1 1 %h %h",
                         i, seen, w, a, d, exp_a[i], exp_d[i]);
            end
        end
        checks++;
        if (bus.empty_o !== 1'b1) begin
            errors++;
            $display("FAIL merge_empty: got %b expected 1", bus.empty_o);
        end
    endtask

    task automatic test_read_miss();
        bit            ok, seen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        logic [DW-1:0] pat = {8{32'h600DF00D}};
        cache_write(32'h000, DW'(32'hD0), 4, ok);
        cache_write(32'h020, DW'(32'hD1), 4, ok);
        bus.cache_cs_i   = 1'b1;
        bus.cache_we_i   = 1'b0;
        bus.cache_addr_i = 32'h400;
        mem_serve(2, seen, a, d, w);
        checks++;
        if ({seen, w, a, d} !== {1'b1, 1'b1, 32'h000, DW'(32'hD0)}) begin
            errors++;
            $display("FAIL miss_first_drain: seen %b we %b addr %h data %h expected 1 1 000 d0",
                     seen, w, a, d);
        end
        checks++;
        if ({bus.mem_cs_o, bus.cache_ack_o} !== 2'b00) begin
            errors++;
            $display("FAIL miss_gap: cs/ack got %b expected 00", {bus.mem_cs_o, bus.cache_ack_o});
        end
        tick();
        checks++;
        if ({bus.mem_cs_o, bus.mem_we_o, bus.mem_addr_o} !== {2'b10, 32'h400}) begin
            errors++;
            $display("FAIL miss_read_issue: cs/we %b addr %h expected 10 addr 400",
                     {bus.mem_cs_o, bus.mem_we_o}, bus.mem_addr_o);
        end
        bus.mem_data_i = pat;
        bus.mem_ack_i  = 1'b1;
        tick();
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        checks++;
        if ({bus.cache_ack_o, bus.cache_data_o} !== {1'b1, pat}) begin
            errors++;
            $display("FAIL miss_rd_data: ack %b data %h expected 1 %h",
                     bus.cache_ack_o, bus.cache_data_o, pat);
        end
        bus.cache_cs_i = 1'b0;
        mem_serve(1, seen, a, d, w);
        checks++;
        if ({seen, w, a, d} !== {1'b1, 1'b1, 32'h020, DW'(32'hD1)} || bus.empty_o !== 1'b1) begin
            errors++;
            $display("FAIL miss_last_drain: seen %b we %b addr %h data %h empty %b expected 1 1 020 d1 empty 1",
                     seen, w, a, d, bus.empty_o);
        end
    endtask

    task automatic test_ignored_ack();
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        tick();
        checks++;
        if ({bus.mem_cs_o, bus.empty_o, bus.cache_ack_o} !== 3'b010) begin
            errors++;
            $display("FAIL stray_mem_ack: cs/empty/ack got %b expected 010",
                     {bus.mem_cs_o, bus.empty_o, bus.cache_ack_o});
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        cache_write(32'h000, DW'(7), 4, ok);
        cache_write(32'h020, DW'(8), 4, ok);
        cache_write(32'h040, DW'(9), 4, ok);
        checks++;
        if ({ok, bus.mem_cs_o, bus.mem_we_o} !== 3'b111) begin
            errors++;
            $display("FAIL rst_drain_pre: ok/cs/we got %b expected 111", {ok, bus.mem_cs_o, bus.mem_we_o});
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.mem_cs_o, bus.empty_o, bus.cache_ack_o, bus.mem_addr_o} !== {3'b010, 32'h0}) begin
            errors++;
            $display("FAIL rst_drain: cs/empty/ack %b addr %h expected 010 addr 0",
                     {bus.mem_cs_o, bus.empty_o, bus.cache_ack_o}, bus.mem_addr_o);
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.mem_cs_o, bus.empty_o} !== 2'b01) begin
            errors++;
            $display("FAIL rst_drain_discard: cs/empty got %b expected 01", {bus.mem_cs_o, bus.empty_o});
        end
        bus.cache_cs_i   = 1'b1;
        bus.cache_we_i   = 1'b0;
        bus.cache_addr_i = 32'h400;
        tick();
        checks++;
        if ({bus.mem_cs_o, bus.mem_we_o, bus.mem_addr_o} !== {2'b10, 32'h400}) begin
            errors++;
            $display("FAIL rst_read_pre: cs/we %b addr %h expected 10 addr 400",
                     {bus.mem_cs_o, bus.mem_we_o}, bus.mem_addr_o);
        end
        rst            = 1'b1;
        bus.cache_cs_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.cache_ack_o, bus.mem_cs_o, bus.empty_o} !== 3'b001) begin
            errors++;
            $display("FAIL rst_read: ack/cs/empty got %b expected 001",
                     {bus.cache_ack_o, bus.mem_cs_o, bus.empty_o});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write();
        test_overflow();
        test_read_hit();
        test_merge();
        test_read_miss();
        test_ignored_ack();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_write_buffer.md
MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, cache-line width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 4, number of buffered write-back lines.
REQ-004 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have cache_addr_i  input  ADDR_WIDTH  line address from L1 cache; bits [4:0] ignored.
REQ-007 SHALL have cache_data_i  input  DATA_WIDTH  write-back line from L1 cache.
REQ-008 SHALL have cache_cs_i  input  1  cache request valid, held until cache_ack_o.
REQ-009 SHALL have cache_we_i  input  1  1 = write-back, 0 = line fill read.
REQ-010 SHALL have cache_data_o  output  DATA_WIDTH  read data to cache, valid with cache_ack_o.
REQ-011 SHALL have cache_ack_o  output  1  one-cycle completion pulse to cache.
REQ-012 SHALL have mem_addr_o  output  ADDR_WIDTH  address to external memory.
REQ-013 SHALL have mem_data_o  output  DATA_WIDTH  write data to external memory.
REQ-014 SHALL have mem_cs_o  output  1  memory request, held until mem_ack_i.
REQ-015 SHALL have mem_we_o  output  1  memory write enable.
REQ-016 SHALL have mem_data_i  input  DATA_WIDTH  read data from memory, valid with mem_ack_i.
REQ-017 SHALL have mem_ack_i  input  1  one-cycle completion pulse from memory.
REQ-018 SHALL have empty_o  output  1  high when buffer holds no entries and no memory transaction in flight.

Function
REQ-019 SHALL hold DEPTH entries {line_addr = addr[ADDR_WIDTH-1:5], data}, FIFO order, count 0..DEPTH.
REQ-020 SHALL implement states IDLE, DRAIN (memory write in flight), READ (memory read in flight).
REQ-021 SHALL ignore cache_cs_i in any cycle where cache_ack_o = 1 (no double acceptance).
REQ-022 Cache write, line matches a buffered entry not in flight: overwrite that entry's data, count unchanged, cache_ack_o next cycle.
REQ-023 Cache write, no such match, count < DEPTH: push at the edge sampling cs&we, cache_ack_o next cycle.
REQ-024 Cache write with count = DEPTH: stall (no ack); a pop frees the slot at its edge, push accepted the following cycle.
REQ-025 Cache read matching buffered line(s): cache_data_o = youngest matching entry, cache_ack_o next cycle, no memory access.
REQ-026 Cache read with no match: wait for IDLE, then enter READ with mem_cs_o=1, mem_we_o=0, mem_addr_o={line_addr,5'b0}.
REQ-027 Pending read miss SHALL take priority over draining when both could start from IDLE.
REQ-028 READ: on mem_ack_i, register mem_data_i into cache_data_o, pulse cache_ack_o next cycle, return to IDLE.
REQ-029 IDLE with count > 0 and no pending read miss: enter DRAIN, drive head entry with mem_cs_o=1, mem_we_o=1.
REQ-030 DRAIN: hold mem outputs stable until mem_ack_i; at that edge pop head, go IDLE, mem_cs_o=0 next cycle.
REQ-031 mem_cs_o SHALL be low for at least one cycle between consecutive memory transactions.
REQ-032 Entry in flight SHALL never be overwritten; push and pop on the same edge SHALL keep count consistent.
REQ-033 mem_ack_i while mem_cs_o = 0 SHALL be ignored.

Reset
REQ-034 rst=1 at an edge: state IDLE, count 0, all entries discarded, pending read cleared.
REQ-035 During and after reset: cache_ack_o=0, cache_data_o=0, mem_cs_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, empty_o=1.
REQ-036 Reset mid-DRAIN or mid-READ SHALL abandon the transaction without ack to the cache.

Verification
REQ-037 Write 0x400 data 0xAA..AA, memory delay 10 -> ack cycle 1, mem write 0x400 issued cycle 2, empty_o=1 after mem_ack_i.
REQ-038 Five writes to lines 0x000,0x020,0x040,0x060,0x080 with memory stalled -> four acks, fifth stalls until first pop, then acked.
REQ-039 Write 0x020 data 0x11, then read 0x020 before drain -> read acked next cycle with 0x11, no mem read.
REQ-040 Two writes to 0x040 (0x1 then 0x2) while head is 0x000 in flight -> count 2, memory receives 0x2 for 0x040 only once.
REQ-041 Read miss 0x400 while 0x000 draining -> mem read starts after drain ack plus one idle cycle, before remaining drains.
REQ-042 Assert rst during DRAIN with count 3 -> next cycle mem_cs_o=0, empty_o=1, no cache_ack_o.
